// File: rtl/note_highway.sv
// rtl/note_highway.sv - note-row queue and scrolling highway driving the strike-line intersections
module note_highway #(
    parameter int          DEPTH      = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] NOTE_ADDR  = 12'hF00,
    parameter logic [11:0] CLEAR_ADDR = 12'hF01
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          gameclk,
    input  logic                          wren,
    input  logic [11:0]                   address_dmem,
    input  logic [31:0]                   data,
    output logic [3:0]                    intersections,
    output logic [4*DEPTH-1:0]            highway,
    output logic                          tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int             PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    FULL_COUNT = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]    COUNT_ONE  = 1;
    localparam logic [PW-1:0]  PTR_ONE    = 1;

    logic          sync1, sync2, prev;
    logic [3:0]    rows [DEPTH];
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push_req, clear_req, pop, push_ok;

    // Only the low nibble of the write data carries lane bits.
    logic          unused_data;
    assign unused_data = ^data[31:4];

    assign push_req  = wren && (address_dmem == NOTE_ADDR);
    assign clear_req = wren && (address_dmem == CLEAR_ADDR);
    assign tick      = sync2 & ~prev;
    assign pop       = tick && (fifo_count != '0);
    // A full queue still accepts a row when the same cycle's tick frees a slot.
    assign push_ok   = push_req && ((fifo_count != FULL_COUNT) || pop);
    assign fifo_full = (fifo_count == FULL_COUNT);
    assign intersections = rows[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign highway[4*k +: 4] = rows[k];
    end

    // Bring gameclk into the clock domain and remember the last level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= gameclk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Queue storage; stale entries past the pointers are never read.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data[3:0];
        end
    end

    // Queue pointers, occupancy and the sticky dropped-row flag.
    always_ff @(posedge clock) begin
        if (reset || clear_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + COUNT_ONE;
            end else if (pop && !push_ok) begin
                fifo_count <= fifo_count - COUNT_ONE;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Scroll the highway one row toward the strike line on each tick, feeding the top from the queue.
    always_ff @(posedge clock) begin
        if (reset || clear_req) begin
            for (int k = 0; k < DEPTH; k++) begin
                rows[k] <= 4'b0000;
            end
        end else if (tick) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                rows[k] <= rows[k+1];
            end
            rows[DEPTH-1] <= pop ? fifo_mem[rd_ptr] : 4'b0000;
        end
    end

endmodule

// File: tb/tb_note_highway.sv
// tb/tb_note_highway.sv - scoreboard bench for note_highway with DEPTH=4, FIFO_DEPTH=8
module tb_note_highway;

    logic        clock, reset, gameclk, wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [3:0]  intersections;
    logic [15:0] highway;
    logic        tick;
    logic [3:0]  fifo_count;
    logic        fifo_full, overflow;

    note_highway #(.DEPTH(4), .FIFO_DEPTH(8), .NOTE_ADDR(12'hF00), .CLEAR_ADDR(12'hF01)) dut (
        .clock(clock), .reset(reset), .gameclk(gameclk), .wren(wren),
        .address_dmem(address_dmem), .data(data), .intersections(intersections),
        .highway(highway), .tick(tick), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] hw;
        logic [3:0]  cnt;
        logic [3:0]  ints;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_count = 0;
    logic pending = 0;
    logic tick_prev = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Monitor: after every tick, the following cycle shows the scrolled state.
    always @(negedge clock) begin
        exp_t e;
        if (pending) begin
            pending = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: highway=%h count=%0d with no expected entry", highway, fifo_count);
            end else begin
                e = exp_q.pop_front();
                if (highway !== e.hw || fifo_count !== e.cnt || intersections !== e.ints) begin
                    errors++;
                    $display("FAIL tick_result: got hw=%h cnt=%0d ints=%b, want hw=%h cnt=%0d ints=%b",
                             highway, fifo_count, intersections, e.hw, e.cnt, e.ints);
                end
            end
        end
        if (tick_prev) begin
            checks++;
            if (tick) begin
                errors++;
                $display("FAIL tick_width: tick high for two consecutive cycles, got 1 want 0");
            end
        end
        if (tick && !reset) begin
            tick_count++;
            pending = 1;
        end
        tick_prev = tick;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [11:0] a, input logic [3:0] d);
        wren = 1; address_dmem = a; data = {28'h0, d};
        wait_cycles(1);
        wren = 0; address_dmem = 12'h000; data = 32'h0;
    endtask

    // One gameclk pulse; tick is high during the third cycle, where an optional write is placed.
    task automatic tick_expect(input logic [15:0] hw, input logic [3:0] cnt,
                               input logic do_wr, input logic [11:0] a, input logic [3:0] d);
        exp_t e;
        e.hw = hw; e.cnt = cnt; e.ints = hw[3:0];
        exp_q.push_back(e);
        gameclk = 1;
        wait_cycles(2);
        if (do_wr) begin
            wren = 1; address_dmem = a; data = {28'h0, d};
        end
        wait_cycles(1);
        wren = 0; address_dmem = 12'h000; data = 32'h0;
        wait_cycles(2);
        gameclk = 0;
        wait_cycles(4);
    endtask

    initial begin
        int base;
        exp_t e;
        reset = 1; gameclk = 1; wren = 1; address_dmem = 12'hF00; data = 32'h5;
        e.hw = 16'h0000; e.cnt = 4'd0; e.ints = 4'd0;
        exp_q.push_back(e);
        @(negedge clock);
        check("reset_highway", {16'h0, highway}, 32'h0);
        check("reset_intersections", {28'h0, intersections}, 32'h0);
        check("reset_count", {28'h0, fifo_count}, 32'h0);
        check("reset_flags", {29'h0, fifo_full, overflow, tick}, 32'h0);
        @(posedge clock); #1;
        reset = 0; wren = 0; address_dmem = 12'h000; data = 32'h0;
        wait_cycles(6);
        gameclk = 0;
        wait_cycles(4);
        check("reset_one_tick", tick_count, 1);

        // Scroll latency
        write(12'hF00, 4'b0001);
        write(12'hF00, 4'b0010);
        write(12'hF00, 4'b0100);
        write(12'hF00, 4'b1000);
        check("queued_four", {28'h0, fifo_count}, 4);
        tick_expect(16'h1000, 3, 0, 12'h000, 0);
        tick_expect(16'h2100, 2, 0, 12'h000, 0);
        tick_expect(16'h4210, 1, 0, 12'h000, 0);
        tick_expect(16'h8421, 0, 0, 12'h000, 0);
        tick_expect(16'h0842, 0, 0, 12'h000, 0);

        // Overflow
        for (int i = 1; i <= 8; i++) write(12'hF00, 4'(i));
        check("full_count", {28'h0, fifo_count}, 8);
        check("full_flag", {31'h0, fifo_full}, 1);
        check("no_overflow_yet", {31'h0, overflow}, 0);
        write(12'hF00, 4'd9);
        check("overflow_set", {31'h0, overflow}, 1);
        check("count_after_drop", {28'h0, fifo_count}, 8);
        tick_expect(16'h1084, 8, 1, 12'hF00, 4'hA);
        check("overflow_sticky", {31'h0, overflow}, 1);
        check("full_after_pushpop", {31'h0, fifo_full}, 1);

        // Drain to three queued rows, then clear on a tick
        tick_expect(16'h2108, 7, 0, 12'h000, 0);
        tick_expect(16'h3210, 6, 0, 12'h000, 0);
        tick_expect(16'h4321, 5, 0, 12'h000, 0);
        tick_expect(16'h5432, 4, 0, 12'h000, 0);
        tick_expect(16'h6543, 3, 0, 12'h000, 0);
        check("overflow_before_clear", {31'h0, overflow}, 1);
        tick_expect(16'h0000, 0, 1, 12'hF01, 0);
        check("overflow_cleared", {31'h0, overflow}, 0);

        // Push and tick together on an empty queue
        tick_expect(16'h0000, 1, 1, 12'hF00, 4'hF);
        tick_expect(16'hF000, 0, 0, 12'h000, 0);

        // Asynchronous gameclk with writes to an unrelated address
        e.cnt = 0;
        for (int i = 0; i < 20; i++) begin
            e.hw = (i == 0) ? 16'h0F00 : (i == 1) ? 16'h00F0 : (i == 2) ? 16'h000F : 16'h0000;
            e.ints = e.hw[3:0];
            exp_q.push_back(e);
        end
        base = tick_count;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    gameclk = 1;
                    #(35 + (i % 4) * 7);
                    gameclk = 0;
                    #(33 + (i % 3) * 9);
                end
            end
            begin
                for (int j = 0; j < 50; j++) begin
                    write(12'h000, 4'hF);
                    wait_cycles(2);
                end
            end
        join
        wait_cycles(6);
        check("sync_tick_count", tick_count - base, 20);
        check("sync_no_overflow", {31'h0, overflow}, 0);
        check("sync_count_zero", {28'h0, fifo_count}, 0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) wait_cycles(1);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_highway.md
Name: note_highway

Overview:
- Transmitter side of the Guitar Hero `intersections[3:0]` interface consumed by the processor.
- The processor queues note rows through memory-mapped stores on the dmem write bus (wren/address/data).
- On every game tick the block scrolls a DEPTH-row highway toward the strike line.
- The bottom row drives `intersections`; the full highway is exported for display logic.

Parameters:
- DEPTH, 16, number of highway rows including the strike row (row 0); legal range ≥2.
- FIFO_DEPTH, 8, entries in the note-row input queue; must be a power of 2.
- NOTE_ADDR, 12'hF00, dmem address whose write pushes data[3:0] as one note row.
- CLEAR_ADDR, 12'hF01, dmem address whose write clears highway, queue and overflow.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- gameclk  in  1  slow game tick, asynchronous to clock.
- wren  in  1  dmem write enable from processor.
- address_dmem  in  12  dmem address; only bits [11:0] are compared.
- data  in  32  dmem write data; only data[3:0] is used (bit i = lane i).
- intersections  out  4  strike row, equal to row 0 of the highway.
- highway  out  4*DEPTH  all rows; bits [4k+3:4k] = row k, row DEPTH-1 = entry (top).
- tick  out  1  one-clock pulse per detected gameclk rising edge.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued rows, 0..FIFO_DEPTH.
- fifo_full  out  1  fifo_count == FIFO_DEPTH.
- overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset (synchronous; takes priority over all other events):
  - All rows 0, so intersections=0 and highway=0.
  - FIFO pointers and count 0; fifo_full=0; overflow=0.
  - sync1, sync2 and prev all 0.
- Tick generation:
  - gameclk passes through a 2-flop synchronizer (sync1→sync2); prev <= sync2.
  - tick = sync2 & ~prev, combinational from registers; high for exactly 1 clock per gameclk rise.
  - Latency: tick asserts in the 2nd or 3rd clock after the gameclk rising edge.
  - gameclk high at reset release counts as a rising edge and produces one tick.
- Push: push_req = wren && address_dmem==NOTE_ADDR.
  - Accepted if count<FIFO_DEPTH, or count==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the row is dropped and overflow <= 1.
  - A pushed value of 4'b0000 is a legal rest row and is queued like any other.
- Scroll on tick:
  - row[k] <= row[k+1] for k=0..DEPTH-2.
  - If count>0: row[DEPTH-1] <= FIFO head, and the head is popped.
  - If count==0: row[DEPTH-1] <= 4'b0000.
  - The previous row 0 is discarded.
- No bypass: a push and a tick on the same cycle with an empty FIFO inserts 0 at the top; the pushed row is queued and enters on the next tick.
- Push and pop on the same cycle: count unchanged, pointers both advance (wrap modulo FIFO_DEPTH).
- Clear: clear_req = wren && address_dmem==CLEAR_ADDR.
  - Next cycle: rows 0, FIFO empty, overflow 0.
  - Clear wins over a tick or push in the same cycle; the tick's scroll is lost.
  - Tick-generation registers are not cleared.
- Latency: a row loaded at the top on tick n appears on intersections in the cycle after tick n+DEPTH-1 and remains for one tick period.
- Writes to any other address are ignored; this block never drives the dmem read path.
- Outputs are registered state or simple decodes of it: intersections=row 0, fifo_full from count, tick from sync2/prev.

Test Plan:
- Reset: hold reset 2 cycles with gameclk=1 and wren=1 to NOTE_ADDR → all outputs 0 during reset; exactly one tick after release; top row 0 because no push was accepted under reset.
- Scroll latency (DEPTH=4): push 4'b0001, 4'b0010, 4'b0100, 4'b1000, then 5 gameclk pulses → intersections = 0001 after tick 4, 0010 after tick 5; highway top = 0000 after tick 5; fifo_count 4→0.
- Overflow (FIFO_DEPTH=8): push 9 rows with no tick → fifo_count=8, fifo_full=1, overflow=1. Then a 10th push coincident with tick → accepted, count stays 8, overflow stays 1.
- Simultaneous push+tick on empty FIFO: push 4'b1111 in the tick cycle → top row 0000 and fifo_count=1; next tick → top row 1111, fifo_count=0.
- Clear mid-operation: highway partially filled, 3 rows queued, overflow=1. Write CLEAR_ADDR in the same cycle as a tick → next cycle highway=0, intersections=0, fifo_count=0, overflow=0.
- Synchronizer: gameclk toggled asynchronously, high ≥3 clocks and low ≥3 clocks, for 20 periods → exactly 20 tick pulses, each 1 clock wide; wren to address 12'h000 during this causes no state change.
